memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive data grants made while an instruction request is pending.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the grant-cycle count without ACCESS that sets the timeout flag.
REQ-003 Port CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port nRST  input  1  reset; it SHALL be asynchronous and active-low.
REQ-005 Port iREN  input  1  instruction read request.
REQ-006 Port iaddr  input  32  instruction address.
REQ-007 Port iwait  output  1  instruction requester wait; 0 means the access completes this cycle.
REQ-008 Port iload  output  32  instruction read data.
REQ-009 Port dREN, dWEN  input  1 each  data read and data write requests.
REQ-010 Port daddr, dstore  input  32 each  data address and data write data.
REQ-011 Port dwait  output  1  data requester wait; 0 means the access completes this cycle.
REQ-012 Port dload  output  32  data read data.
REQ-013 Port ramREN, ramWEN  output  1 each  RAM read and write strobes.
REQ-014 Port ramaddr, ramstore  output  32 each  RAM address and RAM write data.
REQ-015 Port ramload  input  32  RAM read data.
REQ-016 Port ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-017 Port err  output  1  sticky flag recording that ERROR was seen during a grant.
REQ-018 Port tmo  output  1  sticky flag recording a TIMEOUT event.

Function
REQ-019 The FSM SHALL have three states, IDLE, IGNT and DGNT; the state register SHALL be the only grant storage.
REQ-020 A data request SHALL be defined as dREN|dWEN; when both are high, the request SHALL be treated as a write (ramWEN=1, ramREN=0).
REQ-021 In IDLE, all RAM outputs SHALL be 0, iwait=dwait=1 and iload=dload=0.
REQ-022 In IDLE with a data request pending, the next state SHALL be DGNT, unless iREN=1 and the starve counter equals STARVE_LIMIT, in which case it SHALL be IGNT.
REQ-023 In IDLE with only iREN pending, the next state SHALL be IGNT; with no request pending, the FSM SHALL stay in IDLE.
REQ-024 In IGNT, the RAM outputs SHALL be driven combinationally from the instruction requester: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-025 In DGNT, the RAM outputs SHALL be driven combinationally from the data requester: ramREN=dREN&~dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
REQ-026 While granted, if ramstate=ACCESS, the granted requester's wait SHALL be 0 in that same cycle and its load SHALL equal ramload; the next state SHALL be IDLE.
REQ-027 While granted, the non-granted requester's wait SHALL be 1 and its load SHALL be 0.
REQ-028 While granted, ramstate BUSY or FREE SHALL hold the grant, keeping wait=1 and continuing to drive the RAM.
REQ-029 While granted, ramstate ERROR SHALL hold the grant as a retry and SHALL set err on the next edge.
REQ-030 If the granted requester drops its request before ACCESS, the RAM strobes SHALL go to 0 in that cycle and the next state SHALL be IDLE.
REQ-031 The arbiter SHALL never preempt a grant; a higher-priority request arriving mid-grant SHALL wait for IDLE.
REQ-032 Minimum latency SHALL be 2 cycles from request to wait=0: IDLE arbitration in cycle 0, then ACCESS in cycle 1. One IDLE cycle SHALL separate back-to-back grants.
REQ-033 The starve counter SHALL be $clog2(STARVE_LIMIT+1) bits wide and SHALL saturate at STARVE_LIMIT.
REQ-034 The starve counter SHALL increment on each IDLE->DGNT transition taken while iREN=1.
REQ-035 The starve counter SHALL clear on each IDLE->IGNT transition, and on each IDLE->DGNT transition taken while iREN=0.
REQ-036 The grant counter SHALL be $clog2(TIMEOUT+1) bits wide, SHALL clear on entering IGNT or DGNT, and SHALL increment each granted cycle without ACCESS.
REQ-037 When the grant counter reaches TIMEOUT, tmo SHALL be set; the grant SHALL NOT be released and the counter SHALL saturate.
REQ-038 err and tmo SHALL clear only on reset.

Reset
REQ-039 While nRST=0, the FSM SHALL be IDLE and both counters, err and tmo SHALL be 0.
REQ-040 While nRST=0, all outputs SHALL take the IDLE values immediately, independent of CLK.
REQ-041 Reset asserted mid-grant SHALL drop ramREN and ramWEN in the same cycle and SHALL complete no access.
REQ-042 After nRST rises, the first arbitration SHALL occur on the first rising edge.

Verification
REQ-043 Scenario single read: iREN=1, iaddr=0x100, RAM returns ACCESS on the 2nd granted cycle with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x100 from cycle 1; iwait=0 and iload=0xDEADBEEF in cycle 2 only; IDLE in cycle 3.
REQ-044 Scenario simultaneous requests: iREN=1 and dWEN=1 (daddr=0x200, dstore=0x12345678) together, RAM always ACCESS -> DGNT first with ramWEN=1 and ramstore=0x12345678; IGNT follows after one IDLE cycle.
REQ-045 Scenario starvation: iREN held high, data request held high, STARVE_LIMIT=4, RAM always ACCESS -> exactly 4 DGNT grants, then 1 IGNT, then the pattern repeats.
REQ-046 Scenario error and timeout: with TIMEOUT=8, a DGNT in which ramstate=ERROR for 3 cycles, then ACCESS -> err=1 and tmo=0 with completion; a DGNT held BUSY for 10 cycles -> tmo=1 at grant cycle 8 and the grant is still held.
REQ-047 Scenario withdraw and reset: iREN dropped in the 2nd IGNT cycle -> ramREN=0 that cycle and IDLE next; nRST pulsed low mid-DGNT -> ramWEN=0 immediately and err=tmo=0.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the RAM and memory_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter: data has priority, instruction fetch is protected from
// starvation, grants are never preempted, with sticky error and timeout flags.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            CLK,
  input  logic            nRST,
  memory_arbiter_if.slave bus,
  output logic            err,
  output logic            tmo
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [GW-1:0] GRANT_MAX  = GW'(TIMEOUT);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [GW-1:0] grant_cnt;

  logic dreq;
  logic gnt_req;
  logic ram_access;
  logic starve_hit;

  // A simultaneous read+write from the data side counts as a single write request.
  assign dreq       = bus.dREN | bus.dWEN;
  assign gnt_req    = (state == IGNT) ? bus.iREN : dreq;
  assign ram_access = (bus.ramstate == RAM_ACCESS);
  assign starve_hit = bus.iREN && (starve_cnt == STARVE_MAX);

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every register samples pre-edge values regardless of order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      grant_cnt  <= '0;
      err        <= 1'b0;
      tmo        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !starve_hit) begin
            state      <= DGNT;
            grant_cnt  <= '0;
            // starve_hit is false here, so the increment can never pass STARVE_MAX.
            starve_cnt <= bus.iREN ? starve_cnt + 1'b1 : '0;
          end else if (bus.iREN) begin
            state      <= IGNT;
            grant_cnt  <= '0;
            starve_cnt <= '0;
          end
        end
        default: begin
          // A grant ends only on completion or withdrawal; timeout just flags it.
          if (ram_access || !gnt_req) state <= IDLE;
          if (!ram_access) begin
            if (grant_cnt != GRANT_MAX) grant_cnt <= grant_cnt + 1'b1;
            if (grant_cnt >= GRANT_MAX - 1'b1) tmo <= 1'b1;
          end
          if (bus.ramstate == RAM_ERROR) err <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state)
      IGNT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        if (ram_access) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      DGNT: begin
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (ram_access) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

endmodule
